// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg: shared types and AXI constants for the
// multi-requester AXI4 read arbiter.
package mem_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    ADDR  = 2'd2
  } state_t;

  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         BEAT_BYTES     = 16;
  localparam int         BEAT_LG2       = 4;

endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter, one-hot grant, priority
// pointer moves past the winner on accept.
module rr_arb #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/mem_rd_arb.sv
// mem_rd_arb: arbitrates read requests onto one AXI4 AR
// channel, splitting at boundaries, and routes R beats by id.
module mem_rd_arb
  import mem_rd_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int BOUND_LG2 = 11
) (
  input  logic              mem_clk,
  input  logic              mem_reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*27-1:0] req_addr,
  input  logic [NREQ*9-1:0] req_words,
  output logic [NREQ-1:0]   req_busy,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [127:0]      rsp_data,
  output logic [NREQ-1:0]   rsp_last,
  output logic [NREQ-1:0]   rsp_err,
  output logic [3:0]        mem_arid,
  output logic [26:0]       mem_araddr,
  output logic [7:0]        mem_arlen,
  output logic [2:0]        mem_arsize,
  output logic [1:0]        mem_arburst,
  output logic              mem_arlock,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic              mem_rready,
  input  logic [3:0]        mem_rid,
  input  logic [127:0]      mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rlast,
  input  logic              mem_rvalid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [8:0] ROOM_MAX =
    9'(1 << (BOUND_LG2 - BEAT_LG2));

  state_t          state, state_n;
  logic [NREQ-1:0] elig, grant, busy, err;
  logic [PW-1:0]   gidx, cur, ri;
  logic            accept, ar_fire, rid_ok, hit;
  logic [26:0]     addr;
  logic [8:0]      remaining, burst, room, burst_n;
  logic [7:0]      len;
  logic [26:0]     addr_in  [NREQ];
  logic [8:0]      words_in [NREQ];
  logic [8:0]      beat_cnt [NREQ];
  logic            unused_ok;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_in[i]  = req_addr[i*27 +: 27];
    assign words_in[i] = (req_words[i*9 +: 9] == 9'd0) ?
                         9'd1 : req_words[i*9 +: 9];
  end

  assign elig = req_valid & ~busy;

  rr_arb #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .clk    (mem_clk),
    .rst_n  (mem_reset),
    .req    (elig),
    .accept (accept),
    .grant  (grant),
    .gidx   (gidx)
  );

  // 9-bit math keeps room=128 and remaining=256 exact
  assign room    = ROOM_MAX - 9'(addr[BOUND_LG2-1:BEAT_LG2]);
  assign burst_n = (remaining < room) ? remaining : room;
  assign burst   = 9'(len) + 9'd1;

  assign rid_ok = {28'd0, mem_rid} < 32'(NREQ);
  assign ri     = mem_rid[PW-1:0];
  assign hit    = mem_rvalid && rid_ok && busy[ri];

  always_ff @(posedge mem_clk or negedge mem_reset) begin
    if (!mem_reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    ar_fire = 1'b0;
    unique case (state)
      IDLE: begin
        if (|elig) begin
          accept  = 1'b1;
          state_n = SPLIT;
        end
      end
      SPLIT: state_n = ADDR;
      ADDR: begin
        if (mem_arready) begin
          ar_fire = 1'b1;
          state_n = (remaining == burst) ? IDLE : SPLIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge mem_reset) begin
    if (!mem_reset) begin
      req_ready <= '0;
      busy      <= '0;
      err       <= '0;
      rsp_valid <= '0;
      rsp_last  <= '0;
      rsp_data  <= '0;
      cur       <= '0;
      addr      <= '0;
      remaining <= '0;
      len       <= '0;
      for (int i = 0; i < NREQ; i++) beat_cnt[i] <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_last  <= '0;
      if (accept) begin
        req_ready      <= grant;
        cur            <= gidx;
        addr           <= {addr_in[gidx][26:4], 4'b0000};
        remaining      <= words_in[gidx];
        beat_cnt[gidx] <= words_in[gidx];
        busy[gidx]     <= 1'b1;
        err[gidx]      <= 1'b0;
      end
      if (state == SPLIT) len <= 8'(burst_n - 9'd1);
      if (ar_fire) begin
        addr      <= addr + (27'(burst) << BEAT_LG2);
        remaining <= remaining - burst;
      end
      if (hit) begin
        rsp_data      <= mem_rdata;
        rsp_valid[ri] <= 1'b1;
        beat_cnt[ri]  <= beat_cnt[ri] - 9'd1;
        if (beat_cnt[ri] == 9'd1) begin
          rsp_last[ri] <= 1'b1;
          busy[ri]     <= 1'b0;
        end
        if (mem_rresp != 2'b00) err[ri] <= 1'b1;
      end
    end
  end

  assign req_busy    = busy;
  assign rsp_err     = err;
  assign mem_arvalid = (state == ADDR);
  assign mem_arid    = 4'(cur);
  assign mem_araddr  = addr;
  assign mem_arlen   = len;
  assign mem_arsize  = AXI_SIZE_16B;
  assign mem_arburst = AXI_BURST_INCR;
  assign mem_arlock  = 1'b0;
  assign mem_rready  = 1'b1;
  assign unused_ok   = ^{mem_rlast, req_addr, mem_rid};

endmodule

// File: tb/tb_mem_rd_arb.sv
// tb_mem_rd_arb: directed scenarios for mem_rd_arb with
// hand-computed AR fields and response routing.
module tb_mem_rd_arb;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*27-1:0] req_addr;
  logic [NREQ*9-1:0] req_words;
  logic [NREQ-1:0]   req_busy;
  logic [NREQ-1:0]   rsp_valid;
  logic [127:0]      rsp_data;
  logic [NREQ-1:0]   rsp_last;
  logic [NREQ-1:0]   rsp_err;
  logic [3:0]        mem_arid;
  logic [26:0]       mem_araddr;
  logic [7:0]        mem_arlen;
  logic [2:0]        mem_arsize;
  logic [1:0]        mem_arburst;
  logic              mem_arlock;
  logic              mem_arvalid;
  logic              mem_arready;
  logic              mem_rready;
  logic [3:0]        mem_rid;
  logic [127:0]      mem_rdata;
  logic [1:0]        mem_rresp;
  logic              mem_rlast;
  logic              mem_rvalid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_rd_arb #(.NREQ(NREQ), .BOUND_LG2(11)) dut (
    .mem_clk     (clk),
    .mem_reset   (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_words   (req_words),
    .req_busy    (req_busy),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .rsp_err     (rsp_err),
    .mem_arid    (mem_arid),
    .mem_araddr  (mem_araddr),
    .mem_arlen   (mem_arlen),
    .mem_arsize  (mem_arsize),
    .mem_arburst (mem_arburst),
    .mem_arlock  (mem_arlock),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_rready  (mem_rready),
    .mem_rid     (mem_rid),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rlast   (mem_rlast),
    .mem_rvalid  (mem_rvalid)
  );

  task automatic set_req(input int i, input logic [26:0] a,
                         input logic [8:0] w);
    req_addr[i*27 +: 27] = a;
    req_words[i*9 +: 9]  = w;
  endtask

  // raise one request, return the accept vector seen next cycle
  task automatic req_go(input int i, input logic [26:0] a,
                        input logic [8:0] w,
                        output logic [NREQ-1:0] rdy);
    @(negedge clk);
    set_req(i, a, w);
    req_valid[i] = 1'b1;
    @(negedge clk);
    rdy = req_ready;
    req_valid[i] = 1'b0;
  endtask

  task automatic do_ar(output logic [26:0] a, output logic [7:0] l,
                       output logic [3:0] id, output logic ok);
    ok = 1'b0; a = '0; l = '0; id = '0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (mem_arvalid) begin
        a = mem_araddr; l = mem_arlen; id = mem_arid;
        ok = 1'b1; mem_arready = 1'b1;
      end
    end
    @(negedge clk);
    mem_arready = 1'b0;
  endtask

  task automatic do_r(input int id, input int n, input int eb,
                      output int nv, output int nl, output int la,
                      output logic [127:0] ld);
    nv = 0; nl = 0; la = 0; ld = '0;
    for (int b = 1; b <= n + 1; b++) begin
      @(negedge clk);
      if (rsp_valid[id]) nv++;
      if (rsp_last[id]) begin nl++; la = nv; ld = rsp_data; end
      if (b <= n) begin
        mem_rvalid = 1'b1;
        mem_rid    = 4'(id);
        mem_rdata  = 128'(id * 1000 + b);
        mem_rresp  = (b == eb) ? 2'd2 : 2'd0;
        mem_rlast  = (b == n);
      end else begin
        mem_rvalid = 1'b0;
        mem_rresp  = 2'd0;
        mem_rlast  = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_words = '0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rid = '0;
    mem_rdata = '0; mem_rresp = '0; mem_rlast = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid got=%0h want=0", mem_arvalid); end
    checks++; if (req_busy !== 2'b00) begin failures++; $display("FAIL rst_busy got=%0h want=0", req_busy); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_ready got=%0h want=0", req_ready); end
    checks++; if ({rsp_valid, rsp_last, rsp_err} !== 6'd0) begin failures++; $display("FAIL rst_rsp got=%0h want=0", {rsp_valid, rsp_last, rsp_err}); end
    checks++; if ({mem_arid, mem_araddr, mem_arlen} !== 39'd0) begin failures++; $display("FAIL rst_ar got=%0h want=0", {mem_arid, mem_araddr, mem_arlen}); end
    checks++; if ({mem_arsize, mem_arburst, mem_arlock, mem_rready} !== 7'b1000101) begin failures++; $display("FAIL rst_const got=%0b want=1000101", {mem_arsize, mem_arburst, mem_arlock, mem_rready}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] rdy;
    logic [26:0] a; logic [7:0] l; logic [3:0] id; logic ok;
    int nv, nl, la; logic [127:0] ld;
    req_go(0, 27'h000, 9'd80, rdy);
    checks++; if (rdy !== 2'b01) begin failures++; $display("FAIL single_ready got=%0h want=1", rdy); end
    do_ar(a, l, id, ok);
    checks++; if ({ok, id, a, l} !== {1'b1, 4'd0, 27'h000, 8'd79}) begin failures++; $display("FAIL single_ar got=%0h/%0h/%0h/%0h want=1/0/0/4f", ok, id, a, l); end
    checks++; if (req_busy !== 2'b01) begin failures++; $display("FAIL single_busy got=%0h want=1", req_busy); end
    do_r(0, 80, 0, nv, nl, la, ld);
    checks++; if ({nv, nl, la} !== {32'd80, 32'd1, 32'd80}) begin failures++; $display("FAIL single_beats got=%0d/%0d/%0d want=80/1/80", nv, nl, la); end
    checks++; if (ld !== 128'd80) begin failures++; $display("FAIL single_data got=%0h want=50", ld); end
    checks++; if ({req_busy, rsp_err} !== 4'b0000) begin failures++; $display("FAIL single_done got=%0h want=0", {req_busy, rsp_err}); end
  endtask

  task automatic test_split();
    logic [NREQ-1:0] rdy;
    logic [26:0] a; logic [7:0] l; logic [3:0] id; logic ok;
    int nv, nl, la; logic [127:0] ld;
    req_go(0, 27'h7C5, 9'd80, rdy);
    checks++; if (rdy !== 2'b01) begin failures++; $display("FAIL split_ready got=%0h want=1", rdy); end
    do_ar(a, l, id, ok);
    checks++; if ({ok, a, l} !== {1'b1, 27'h7C0, 8'd3}) begin failures++; $display("FAIL split_ar1 got=%0h/%0h/%0h want=1/7c0/3", ok, a, l); end
    do_ar(a, l, id, ok);
    checks++; if ({ok, a, l} !== {1'b1, 27'h800, 8'd75}) begin failures++; $display("FAIL split_ar2 got=%0h/%0h/%0h want=1/800/4b", ok, a, l); end
    do_r(0, 80, 0, nv, nl, la, ld);
    checks++; if ({nv, nl, la} !== {32'd80, 32'd1, 32'd80}) begin failures++; $display("FAIL split_beats got=%0d/%0d/%0d want=80/1/80", nv, nl, la); end
  endtask

  task automatic test_max();
    logic [NREQ-1:0] rdy;
    logic [26:0] a; logic [7:0] l; logic [3:0] id; logic ok;
    logic [26:0] ea [3];
    logic [7:0] el [3];
    int nv, nl, la; logic [127:0] ld;
    ea[0] = 27'h400; ea[1] = 27'h800; ea[2] = 27'h1000;
    el[0] = 8'd63;   el[1] = 8'd127;  el[2] = 8'd63;
    req_go(0, 27'h400, 9'd256, rdy);
    for (int k = 0; k < 3; k++) begin
      do_ar(a, l, id, ok);
      checks++; if ({ok, a, l} !== {1'b1, ea[k], el[k]}) begin failures++; $display("FAIL max_ar%0d got=%0h/%0h/%0h want=1/%0h/%0h", k, ok, a, l, ea[k], el[k]); end
    end
    checks++; if (mem_arvalid !== 1'b0) begin failures++; $display("FAIL max_no_4th got=%0h want=0", mem_arvalid); end
    do_r(0, 256, 0, nv, nl, la, ld);
    checks++; if ({nv, nl, la} !== {32'd256, 32'd1, 32'd256}) begin failures++; $display("FAIL max_beats got=%0d/%0d/%0d want=256/1/256", nv, nl, la); end
  endtask

  task automatic test_contention();
    logic [26:0] a; logic [7:0] l; logic [3:0] id; logic ok;
    logic [3:0] rids [5];
    logic [NREQ-1:0] ev [5];
    logic [NREQ-1:0] el [5];
    rids[0] = 4'd1; rids[1] = 4'd0; rids[2] = 4'd1;
    rids[3] = 4'd0; rids[4] = 4'd0;
    ev[0] = 2'b10; ev[1] = 2'b01; ev[2] = 2'b10; ev[3] = 2'b01; ev[4] = 2'b01;
    el[0] = 2'b00; el[1] = 2'b00; el[2] = 2'b10; el[3] = 2'b00; el[4] = 2'b01;
    @(negedge clk);
    set_req(0, 27'h200, 9'd3);
    set_req(1, 27'h100, 9'd2);
    req_valid = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL cont_first got=%0h want=2", req_ready); end
    req_valid = 2'b01;
    do_ar(a, l, id, ok);
    checks++; if ({ok, id, a, l} !== {1'b1, 4'd1, 27'h100, 8'd1}) begin failures++; $display("FAIL cont_ar1 got=%0h/%0h/%0h/%0h want=1/1/100/1", ok, id, a, l); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL cont_second got=%0h want=1", req_ready); end
    req_valid = 2'b00;
    do_ar(a, l, id, ok);
    checks++; if ({ok, id, a, l} !== {1'b1, 4'd0, 27'h200, 8'd2}) begin failures++; $display("FAIL cont_ar2 got=%0h/%0h/%0h/%0h want=1/0/200/2", ok, id, a, l); end
    checks++; if (req_busy !== 2'b11) begin failures++; $display("FAIL cont_busy got=%0h want=3", req_busy); end
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++; if ({rsp_valid, rsp_last} !== {ev[k-1], el[k-1]}) begin failures++; $display("FAIL cont_beat%0d got=%0b want=%0b", k, {rsp_valid, rsp_last}, {ev[k-1], el[k-1]}); end
        checks++; if (rsp_data !== 128'(k + 500)) begin failures++; $display("FAIL cont_data%0d got=%0h want=%0h", k, rsp_data, k + 500); end
      end
      if (k < 5) begin
        mem_rvalid = 1'b1; mem_rid = rids[k];
        mem_rdata = 128'(k + 501); mem_rresp = 2'd0;
      end else begin
        mem_rvalid = 1'b0;
      end
    end
    checks++; if (req_busy !== 2'b00) begin failures++; $display("FAIL cont_idle got=%0h want=0", req_busy); end
  endtask

  task automatic test_drop();
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rid = 4'd3; mem_rdata = 128'hDEAD;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_last} !== 4'b0000) begin failures++; $display("FAIL drop_rid3 got=%0h want=0", {rsp_valid, rsp_last}); end
    mem_rid = 4'd0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_last} !== 4'b0000) begin failures++; $display("FAIL drop_idle got=%0h want=0", {rsp_valid, rsp_last}); end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_backpressure_err();
    logic [NREQ-1:0] rdy;
    logic [26:0] a; logic [7:0] l; logic [3:0] id; logic ok;
    int nv, nl, la, stable; logic [127:0] ld;
    req_go(0, 27'h000, 9'd5, rdy);
    stable = 0;
    for (int c = 0; c < 20 && !mem_arvalid; c++) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      if ({mem_arvalid, mem_arid, mem_araddr, mem_arlen} === {1'b1, 4'd0, 27'h0, 8'd4}) stable++;
      @(negedge clk);
    end
    checks++; if (stable !== 10) begin failures++; $display("FAIL bp_stable got=%0d want=10", stable); end
    do_ar(a, l, id, ok);
    checks++; if ({ok, a, l} !== {1'b1, 27'h0, 8'd4}) begin failures++; $display("FAIL bp_ar got=%0h/%0h/%0h want=1/0/4", ok, a, l); end
    do_r(0, 5, 3, nv, nl, la, ld);
    checks++; if ({nv, la} !== {32'd5, 32'd5}) begin failures++; $display("FAIL err_beats got=%0d/%0d want=5/5", nv, la); end
    checks++; if ({rsp_err, req_busy} !== 4'b0100) begin failures++; $display("FAIL err_sticky got=%0b want=0100", {rsp_err, req_busy}); end
    // zero-word request behaves as a single beat
    req_go(0, 27'h1235, 9'd0, rdy);
    checks++; if ({rdy, rsp_err, req_busy} !== 6'b010001) begin failures++; $display("FAIL regrant got=%0b want=010001", {rdy, rsp_err, req_busy}); end
    do_ar(a, l, id, ok);
    checks++; if ({ok, a, l} !== {1'b1, 27'h1230, 8'd0}) begin failures++; $display("FAIL w0_ar got=%0h/%0h/%0h want=1/1230/0", ok, a, l); end
    do_r(0, 1, 0, nv, nl, la, ld);
    checks++; if ({nv, nl, la} !== {32'd1, 32'd1, 32'd1}) begin failures++; $display("FAIL w0_beats got=%0d/%0d/%0d want=1/1/1", nv, nl, la); end
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] rdy;
    req_go(1, 27'h040, 9'd4, rdy);
    for (int c = 0; c < 20 && !mem_arvalid; c++) @(negedge clk);
    checks++; if (mem_arvalid !== 1'b1) begin failures++; $display("FAIL mid_addr got=%0h want=1", mem_arvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_arvalid, req_busy} !== 3'b000) begin failures++; $display("FAIL mid_async got=%0b want=000", {mem_arvalid, req_busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    test_single();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_split();
    test_max();
    test_contention();
    test_drop();
    test_backpressure_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
